// File: rtl/register_bank.sv
// 32 x DATA_W register file with A/B operand latches for the multicycle MIPS datapath.
// r0 reads as zero; r29 resets to SP_INIT. BYPASS selects old/new data on same-edge collisions.
module register_bank #(
  parameter int              DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(227),
  parameter bit              BYPASS  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  input  logic              ab_load,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_r [1:31];
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] a_next_s;
  logic [DATA_W-1:0] b_next_s;
  logic              wr_en_s;

  assign wr_en_s = reg_write && (write_reg != 5'd0);

  // Combinational read ports; address 0 has no storage and reads as zero.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    dbg_data   = '0;
    if (read_reg1 != 5'd0) begin
      read_data1 = regs_r[read_reg1];
    end else begin
      read_data1 = '0;
    end
    if (read_reg2 != 5'd0) begin
      read_data2 = regs_r[read_reg2];
    end else begin
      read_data2 = '0;
    end
    if (dbg_addr != 5'd0) begin
      dbg_data = regs_r[dbg_addr];
    end else begin
      dbg_data = '0;
    end
  end

  // Latch capture values; wr_en_s already excludes r0, so r0 never bypasses.
  always_comb begin
    a_next_s = read_data1;
    b_next_s = read_data2;
    if (BYPASS && wr_en_s && (write_reg == read_reg1)) begin
      a_next_s = write_data;
    end else begin
      a_next_s = read_data1;
    end
    if (BYPASS && wr_en_s && (write_reg == read_reg2)) begin
      b_next_s = write_data;
    end else begin
      b_next_s = read_data2;
    end
  end

  // Register storage: reset wins over writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_r[i] <= (i == 29) ? SP_INIT : '0;
      end
    end else if (wr_en_s) begin
      regs_r[write_reg] <= write_data;
    end
  end

  // A/B operand latches: reset wins over ab_load.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r <= '0;
      b_r <= '0;
    end else if (ab_load) begin
      a_r <= a_next_s;
      b_r <= b_next_s;
    end
  end

  assign a_out = a_r;
  assign b_out = b_r;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: two instances (BYPASS=0 and BYPASS=1) share stimulus;
// expectations are queued when stimulus is driven and popped when outputs are sampled.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic        ab_load;
  logic [4:0]  dbg_addr;
  logic [31:0] rd1_0, rd2_0, a_0, b_0, dbg_0;
  logic [31:0] rd1_1, rd2_1, a_1, b_1, dbg_1;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  register_bank #(.DATA_W(32), .SP_INIT(32'd227), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .ab_load(ab_load), .read_data1(rd1_0), .read_data2(rd2_0),
    .a_out(a_0), .b_out(b_0), .dbg_addr(dbg_addr), .dbg_data(dbg_0)
  );

  register_bank #(.DATA_W(32), .SP_INIT(32'd227), .BYPASS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .ab_load(ab_load), .read_data1(rd1_1), .read_data2(rd2_1),
    .a_out(a_1), .b_out(b_1), .dbg_addr(dbg_addr), .dbg_data(dbg_1)
  );

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h with no expectation queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write  = 1'b0;
    write_reg  = 5'd0;
    write_data = 32'd0;
    ab_load    = 1'b0;
    reset      = 1'b0;
  endtask

  initial begin
    idle();
    read_reg1 = 5'd0;
    read_reg2 = 5'd0;
    dbg_addr  = 5'd0;

    // Reset held for two cycles.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      read_reg1 = 5'(a);
      read_reg2 = 5'(a);
      dbg_addr  = 5'(a);
      push("reset_rd1", (a == 29) ? 32'h0000_00E3 : 32'h0);
      push("reset_rd2", (a == 29) ? 32'h0000_00E3 : 32'h0);
      push("reset_dbg", (a == 29) ? 32'h0000_00E3 : 32'h0);
      #1;
      pop_check(rd1_0);
      pop_check(rd2_0);
      pop_check(dbg_0);
    end
    push("reset_a0", 32'h0); push("reset_b0", 32'h0);
    push("reset_a1", 32'h0); push("reset_b1", 32'h0);
    pop_check(a_0); pop_check(b_0); pop_check(a_1); pop_check(b_1);

    // Write r8; not visible until after the edge.
    reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEAD_BEEF;
    read_reg1 = 5'd8;
    push("no_bypass_pre_edge", 32'h0);
    #1;
    pop_check(rd1_0);
    tick();
    write_reg = 5'd31; write_data = 32'h1234_5678;
    tick();
    idle();
    read_reg1 = 5'd8; read_reg2 = 5'd31;
    push("wr_r8", 32'hDEAD_BEEF); push("wr_r31", 32'h1234_5678);
    #1;
    pop_check(rd1_0); pop_check(rd2_0);
    ab_load = 1'b1;
    push("ab_a_r8", 32'hDEAD_BEEF); push("ab_b_r31", 32'h1234_5678);
    tick();
    ab_load = 1'b0;
    pop_check(a_0); pop_check(b_0);

    // r0 discards writes and reads zero.
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF;
    tick();
    idle();
    read_reg1 = 5'd0; read_reg2 = 5'd8;
    push("r0_read", 32'h0);
    #1;
    pop_check(rd1_0);
    ab_load = 1'b1;
    push("r0_latch_a", 32'h0); push("r0_latch_b", 32'hDEAD_BEEF);
    tick();
    ab_load = 1'b0;
    pop_check(a_0); pop_check(b_0);

    // Same-edge collision on r5.
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'h11;
    tick();
    write_data = 32'h22; ab_load = 1'b1;
    read_reg1 = 5'd5; read_reg2 = 5'd5;
    push("coll_bp0_a", 32'h11); push("coll_bp0_b", 32'h11);
    push("coll_bp1_a", 32'h22); push("coll_bp1_b", 32'h22);
    push("coll_rd_bp0", 32'h22); push("coll_rd_bp1", 32'h22);
    tick();
    idle();
    #1;
    pop_check(a_0); pop_check(b_0); pop_check(a_1); pop_check(b_1);
    pop_check(rd1_0); pop_check(rd1_1);

    // Collision on r0 never bypasses.
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hABCD_0123; ab_load = 1'b1;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    push("coll_r0_bp1_a", 32'h0); push("coll_r0_bp1_b", 32'h0);
    tick();
    idle();
    pop_check(a_1); pop_check(b_1);

    // Reset priority over reg_write and ab_load.
    read_reg1 = 5'd29; read_reg2 = 5'd5; ab_load = 1'b1;
    tick();
    reset = 1'b1; reg_write = 1'b1; write_reg = 5'd29; write_data = 32'h55; ab_load = 1'b1;
    push("rstpri_r29", 32'd227);
    push("rstpri_a0", 32'h0); push("rstpri_b0", 32'h0);
    push("rstpri_a1", 32'h0); push("rstpri_b1", 32'h0);
    push("rstpri_r5", 32'h0);
    tick();
    idle();
    #1;
    pop_check(rd1_0);
    pop_check(a_0); pop_check(b_0); pop_check(a_1); pop_check(b_1);
    pop_check(rd2_0);

    // Stack write, then reset returns r29 to its initial value and drops r8.
    reg_write = 1'b1; write_reg = 5'd29; write_data = 32'h100;
    tick();
    reg_write = 1'b1; write_reg = 5'd8; write_data = 32'h77;
    tick();
    idle();
    read_reg1 = 5'd29; read_reg2 = 5'd8; dbg_addr = 5'd29;
    push("sp_write", 32'h100); push("r8_write", 32'h77); push("sp_dbg", 32'h100);
    #1;
    pop_check(rd1_0); pop_check(rd2_0); pop_check(dbg_0);
    reset = 1'b1; reg_write = 1'b1; write_reg = 5'd8; write_data = 32'h99;
    tick();
    idle();
    push("sp_after_reset", 32'd227); push("r8_lost_write", 32'h0);
    #1;
    pop_check(rd1_0); pop_check(rd2_0);

    if (sb_q.size() != 0) begin
      n_err++;
      $error("FAIL scoreboard_leftover: observed %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
